// File: rtl/ipic_lite_cmd_queue.sv
// rtl/ipic_lite_cmd_queue.sv - Tagged command FIFO and sequencer for the IPIC lite single-beat master
// Read-modify-write (op 2) is built only when IPIC_CMDQ_RMW_EN is defined.
module ipic_lite_cmd_queue #(
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_NATIVE_DATA_WIDTH = 32,
  parameter int C_TAG_WIDTH         = 4,
  parameter int C_CMD_DEPTH         = 4,
  parameter int C_TIMEOUT_CYCLES    = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [C_NATIVE_DATA_WIDTH-1:0] cmd_data,
  input  logic [C_NATIVE_DATA_WIDTH-1:0] cmd_mask,
  input  logic [C_TAG_WIDTH-1:0]         cmd_tag,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [C_NATIVE_DATA_WIDTH-1:0] rsp_data,
  output logic [C_TAG_WIDTH-1:0]         rsp_tag,
  output logic                           rsp_err,
  output logic [2:0]                     ipic_type,
  output logic                           ipic_start,
  input  logic                           ipic_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  read_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  write_addr,
  output logic [C_NATIVE_DATA_WIDTH-1:0] write_data,
  input  logic [C_NATIVE_DATA_WIDTH-1:0] single_read_data,
  output logic                           halted
);
  localparam int PW  = $clog2(C_CMD_DEPTH);
  localparam int WDW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(C_TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;
  localparam logic [2:0] S_HALT  = 3'd7;
  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
`ifdef IPIC_CMDQ_RMW_EN
  localparam logic [2:0] S_RMW_ISSUE_WR = 3'd3;
  localparam logic [2:0] S_RMW_WAIT     = 3'd4;
  localparam logic [1:0] OP_RMW         = 2'd2;
`endif

  logic [1:0]                     q_op   [C_CMD_DEPTH];
  logic [C_M_AXI_ADDR_WIDTH-1:0]  q_addr [C_CMD_DEPTH];
  logic [C_NATIVE_DATA_WIDTH-1:0] q_data [C_CMD_DEPTH];
  logic [C_TAG_WIDTH-1:0]         q_tag  [C_CMD_DEPTH];
`ifdef IPIC_CMDQ_RMW_EN
  logic [C_NATIVE_DATA_WIDTH-1:0] q_mask [C_CMD_DEPTH];
  logic [C_NATIVE_DATA_WIDTH-1:0] w_mask;
`else
  logic unused_mask;
  assign unused_mask = ^cmd_mask;
`endif

  logic [2:0]                     state;
  logic [PW:0]                    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [PW-1:0]                  wr_idx, rd_idx;
  logic                           push, pop, empty, full_nxt, go_halt, op_legal, to_halt;
  logic [1:0]                     head_op, w_op;
  logic [C_M_AXI_ADDR_WIDTH-1:0]  w_addr;
  logic [C_NATIVE_DATA_WIDTH-1:0] w_data;
  logic [WDW-1:0]                 wd_cnt;

  // Extra pointer bit separates full from empty when the indices wrap.
  assign wr_idx   = wr_ptr[PW-1:0];
  assign rd_idx   = rd_ptr[PW-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign push     = cmd_valid & cmd_ready;
  assign pop      = (state == S_IDLE) & ~empty;
  assign wr_nxt   = wr_ptr + {{PW{1'b0}}, push};
  assign rd_nxt   = rd_ptr + {{PW{1'b0}}, pop};
  assign full_nxt = (wr_nxt[PW] != rd_nxt[PW]) && (wr_nxt[PW-1:0] == rd_nxt[PW-1:0]);
  assign go_halt  = (state == S_RESP) & rsp_ready & to_halt;
  assign head_op  = q_op[rd_idx];
`ifdef IPIC_CMDQ_RMW_EN
  assign op_legal = (head_op != 2'd3);
`else
  assign op_legal = (head_op == OP_RD) || (head_op == OP_WR);
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_idx]   <= cmd_op;
      q_addr[wr_idx] <= cmd_addr;
      q_data[wr_idx] <= cmd_data;
      q_tag[wr_idx]  <= cmd_tag;
`ifdef IPIC_CMDQ_RMW_EN
      q_mask[wr_idx] <= cmd_mask;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
      ipic_type  <= 3'd0;
      ipic_start <= 1'b0;
      read_addr  <= '0;
      write_addr <= '0;
      write_data <= '0;
      halted     <= 1'b0;
      to_halt    <= 1'b0;
      wd_cnt     <= '0;
      w_op       <= 2'd0;
      w_addr     <= '0;
      w_data     <= '0;
`ifdef IPIC_CMDQ_RMW_EN
      w_mask     <= '0;
`endif
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      cmd_ready  <= ~full_nxt & ~(halted | go_halt);
      ipic_start <= 1'b0;
      case (state)
        S_IDLE: if (pop) begin
          w_op     <= head_op;
          w_addr   <= q_addr[rd_idx];
          w_data   <= q_data[rd_idx];
`ifdef IPIC_CMDQ_RMW_EN
          w_mask   <= q_mask[rd_idx];
`endif
          rsp_tag  <= q_tag[rd_idx];
          rsp_data <= '0;
          rsp_err  <= ~op_legal;
          if (op_legal) state <= S_ISSUE;
          else begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_ISSUE: begin
          ipic_start <= 1'b1;
          ipic_type  <= (w_op == OP_WR) ? 3'd3 : 3'd2;
          read_addr  <= w_addr;
          write_addr <= w_addr;
          write_data <= w_data;
          wd_cnt     <= '0;
          state      <= S_WAIT;
        end
`ifdef IPIC_CMDQ_RMW_EN
        S_RMW_ISSUE_WR: begin
          ipic_start <= 1'b1;
          ipic_type  <= 3'd3;
          write_data <= (rsp_data & ~w_mask) | (w_data & w_mask);
          wd_cnt     <= '0;
          state      <= S_RMW_WAIT;
        end
        S_WAIT, S_RMW_WAIT: begin
`else
        S_WAIT: begin
`endif
          if (ipic_done) begin
`ifdef IPIC_CMDQ_RMW_EN
            // The RMW write phase must not overwrite the pre-modify read value.
            if (state == S_WAIT && w_op != OP_WR) rsp_data <= single_read_data;
            if (state == S_WAIT && w_op == OP_RMW) state <= S_RMW_ISSUE_WR;
            else begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
`else
            if (w_op != OP_WR) rsp_data <= single_read_data;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
`endif
          end else if (wd_cnt == WD_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            to_halt   <= 1'b1;
            state     <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          halted    <= to_halt;
          state     <= to_halt ? S_HALT : S_GAP;
        end
        S_GAP:   state <= S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipic_lite_cmd_queue.sv
// tb/tb_ipic_lite_cmd_queue.sv - Scoreboard bench for ipic_lite_cmd_queue against a memory-level reference model
module tb_ipic_lite_cmd_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, ipic_start, ipic_done, halted;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_data, cmd_mask, rsp_data, read_addr, write_addr, write_data, single_read_data;
  logic [3:0]  cmd_tag, rsp_tag;
  logic [2:0]  ipic_type;

  ipic_lite_cmd_queue #(
    .C_M_AXI_ADDR_WIDTH(32), .C_NATIVE_DATA_WIDTH(32), .C_TAG_WIDTH(4),
    .C_CMD_DEPTH(4), .C_TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .ipic_type(ipic_type), .ipic_start(ipic_start), .ipic_done(ipic_done),
    .read_addr(read_addr), .write_addr(write_addr), .write_data(write_data),
    .single_read_data(single_read_data), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] typ; logic [31:0] addr; logic [31:0] data; } iss_t;
  typedef struct { logic [31:0] data; logic [3:0] tag; logic err; } rsp_t;
  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dn_mem  [logic [31:0]];
  int vectors = 0, miscompares = 0, n_starts = 0, cyc = 0, last_start = -100;
  int fix_lat = 0;
  bit rsp_hold = 0, dn_mute = 0;
  logic dn_done = 1'b0, late_done = 1'b0;
  assign ipic_done = dn_done | late_done;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [159:0] outs();
    return {cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, ipic_type, ipic_start,
            read_addr, write_addr, write_data, halted};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    dn_mem[a]  = d;
  endtask

  // Expected effect of one accepted command, in program order.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] t, input bit tmo);
    if (tmo) begin
      exp_iss.push_back('{3'd2, a, 32'd0});
      exp_rsp.push_back('{32'd0, t, 1'b1});
    end else if (op == 2'd0) begin
      exp_iss.push_back('{3'd2, a, 32'd0});
      exp_rsp.push_back('{ref_rd(a), t, 1'b0});
    end else if (op == 2'd1) begin
      ref_mem[a] = d;
      exp_iss.push_back('{3'd3, a, d});
      exp_rsp.push_back('{32'd0, t, 1'b0});
    end
`ifdef IPIC_CMDQ_RMW_EN
    else if (op == 2'd2) begin
      logic [31:0] old;
      old = ref_rd(a);
      ref_mem[a] = (old & ~cmd_mask) | (d & cmd_mask);
      exp_iss.push_back('{3'd2, a, 32'd0});
      exp_iss.push_back('{3'd3, a, ref_mem[a]});
      exp_rsp.push_back('{old, t, 1'b0});
    end
`endif
    else exp_rsp.push_back('{32'd0, t, 1'b1});
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called and returns just after a rising edge, so sends can run back-to-back.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] m, input logic [3:0] t, input bit tmo = 1'b0);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_tag = t;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 400);
    chk("cmd_accept", cmd_ready, 1);
    if (cmd_ready) model(op, a, d, t, tmo);
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_iss.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, {exp_rsp.size(), exp_iss.size()}, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      sync();
      rsp_ready = !rsp_hold && ($urandom_range(0, 3) != 0);
    end
  end

  // Downstream single-beat machine backed by its own memory.
  initial begin : responder
    int cnt;
    bit is_wr;
    logic [31:0] rdata;
    cnt = 0; is_wr = 0; rdata = '0; single_read_data = '0;
    forever begin
      sync();
      dn_done = 1'b0;
      if (reset) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            dn_done = 1'b1;
            single_read_data = is_wr ? $urandom : rdata;
          end
        end
        if (ipic_start && !dn_mute) begin
          is_wr = (ipic_type == 3'd3);
          if (is_wr) dn_mem[write_addr] = write_data;
          else rdata = dn_mem.exists(read_addr) ? dn_mem[read_addr] : dflt(read_addr);
          cnt = (fix_lat > 0) ? fix_lat : $urandom_range(1, 8);
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", {1'b1, rsp_tag, rsp_data}, 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp", {rsp_data, rsp_tag, rsp_err}, {e.data, e.tag, e.err});
        end
      end
    end
  end

  initial begin : iss_mon
    iss_t e;
    forever begin
      @(negedge clk);
      if (!reset && ipic_start) begin
        n_starts++;
        chk("start_spacing", (cyc - last_start) >= 2, 1);
        last_start = cyc;
        if (exp_iss.size() == 0) chk("start_unexpected", {1'b1, ipic_type, read_addr}, 0);
        else begin
          e = exp_iss.pop_front();
          if (e.typ == 3'd3) chk("start_wr", {ipic_type, write_addr, write_data}, {e.typ, e.addr, e.data});
          else chk("start_rd", {ipic_type, read_addr}, {e.typ, e.addr});
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "bench stopped");
  end

  initial begin : main
    int s0, r;
    logic [1:0] op;
    logic [36:0] snap;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0; cmd_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_low_first_cycle", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    sync();

    // Single read with a six-cycle downstream.
    preload(32'h4000_0010, 32'hDEAD_BEEF);
    fix_lat = 6;
    s0 = n_starts;
    send(2'd0, 32'h4000_0010, 32'd0, 32'd0, 4'd5);
    drain("read", 200);
    chk("read_start_count", n_starts - s0, 1);
    sync();

    // Five writes into a depth-4 queue while the first response is held.
    rsp_hold = 1;
    fix_lat = 2;
    repeat (2) sync();
    for (int i = 0; i < 5; i++) send(2'd1, 32'h1000_0000 + 32'(4 * i), 32'(i + 1), 32'd0, 4'(i));
    @(negedge clk);
    chk("cmd_ready_full", cmd_ready, 0);
    r = 0;
    while (!rsp_valid && r < 100) begin
      @(negedge clk);
      r++;
    end
    snap = {rsp_data, rsp_tag, rsp_err};
    s0 = n_starts;
    repeat (20) begin
      @(negedge clk);
      chk("bp_stable", {rsp_valid, rsp_data, rsp_tag, rsp_err}, {1'b1, snap});
    end
    chk("bp_no_start", n_starts - s0, 0);
    rsp_hold = 0;
    fix_lat = 0;
    drain("burst", 600);
    sync();

    // Read-modify-write, and the reserved op.
    preload(32'h2000_0040, 32'hFFFF_0000);
    s0 = n_starts;
    send(2'd2, 32'h2000_0040, 32'h0000_1234, 32'h0000_FFFF, 4'd7);
    drain("rmw", 300);
`ifdef IPIC_CMDQ_RMW_EN
    chk("rmw_start_count", n_starts - s0, 2);
    chk("rmw_mem", dn_mem[32'h2000_0040], 32'hFFFF_1234);
`else
    chk("rmw_rejected_no_start", n_starts - s0, 0);
`endif
    sync();
    s0 = n_starts;
    send(2'd3, 32'h2000_0080, 32'h1, 32'h1, 4'd3);
    drain("reserved_op", 100);
    chk("reserved_no_start", n_starts - s0, 0);
    sync();

    // Randomized mix over a small address set so reads hit earlier writes.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      send(op, 32'h3000_0000 + 32'(4 * $urandom_range(0, 7)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) sync();
    end
    drain("random", 4000);
    sync();

    // Downstream never completes.
    dn_mute = 1;
    s0 = n_starts;
    send(2'd0, 32'h5000_0000, 32'd0, 32'd0, 4'd9, 1'b1);
    drain("timeout", 300);
    repeat (2) @(negedge clk);
    chk("halted", halted, 1);
    chk("halt_cmd_ready", cmd_ready, 0);
    sync();
    late_done = 1'b1;
    sync();
    late_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("late_done_ignored", {halted, cmd_ready, rsp_valid, n_starts - s0}, {1'b1, 1'b0, 1'b0, 32'd1});
    sync();

    // Recover, then reset again with one command in flight and two queued.
    reset = 1'b1;
    dn_mute = 0;
    repeat (2) sync();
    reset = 1'b0;
    repeat (2) sync();
    fix_lat = 12;
    send(2'd0, 32'h6000_0000, 32'd0, 32'd0, 4'd1);
    send(2'd0, 32'h6000_0004, 32'd0, 32'd0, 4'd2);
    send(2'd0, 32'h6000_0008, 32'd0, 32'd0, 4'd3);
    repeat (3) sync();
    reset = 1'b1;
    exp_iss.delete();
    exp_rsp.delete();
    sync();
    @(negedge clk);
    chk("reset_mid_wait_outputs", outs(), 0);
    sync();
    reset = 1'b0;
    s0 = n_starts;
    repeat (10) @(negedge clk);
    chk("fifo_empty_after_reset", {rsp_valid, n_starts - s0}, 0);
    sync();
    fix_lat = 0;
    send(2'd0, 32'h6000_0004, 32'd0, 32'd0, 4'd4);
    drain("after_reset", 200);
    chk("after_reset_start_count", n_starts - s0, 1);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
